// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, with a start/busy/done handshake and a pass-through register tag.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [XLEN-1:0]    b_q, b_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [TAG_W-1:0]   tag_out_q, tag_out_d;

    // Operand decode at accept time
    logic              signed_a, signed_b, in_neg_a, in_neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;

    always_comb begin
        signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        in_neg_a = signed_a & src_a[XLEN-1];
        in_neg_b = signed_b & src_b[XLEN-1];
        mag_a    = in_neg_a ? -src_a : src_a;
        mag_b    = in_neg_b ? -src_b : src_b;
        div_zero = funct3[2] && (src_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (src_a == MIN_VAL) && (src_b == '1);
        if (div_zero) begin
            special_res = funct3[1] ? src_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : src_a;
        end
    end

    // One radix-2 step. acc holds {hi, lo}: product high/multiplier for multiply,
    // partial remainder/shifting dividend-quotient for divide.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, b_q} & {(XLEN+1){acc_q[0]}});
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and output select
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        result_d  = result_q;
        tag_out_d = tag_out_q;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = funct3;
                    tag_d   = tag_in;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    cnt_d   = '0;
                    acc_d   = {{XLEN{1'b0}}, mag_a};
                    b_d     = mag_b;
                    if (div_zero || div_ovf) begin
                        result_d  = special_res;
                        tag_out_d = tag_in;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d  = fix_res;
                tag_out_d = tag_q;
                state_d   = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An abort never publishes a result
        if (flush) begin
            state_d   = S_IDLE;
            result_d  = result_q;
            tag_out_d = tag_out_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            tag_out_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            result_q  <= result_d;
            tag_out_q <= tag_out_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign tag_out = tag_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised bench for muldiv_unit: an arithmetic reference model feeds a queue of
// expected completions that a per-cycle checker compares against the DUT outputs.
module tb_muldiv_unit;

    localparam logic [31:0] MIN32 = 32'h8000_0000;
    localparam int          LAT   = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [4:0]  tag_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  tag_out;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .funct3  (funct3),
        .src_a   (src_a),
        .src_b   (src_b),
        .tag_in  (tag_in),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .tag_out (tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    int          cyc = 0;
    int          compared = 0;
    int          mism = 0;
    logic [31:0] model_res = '0;
    logic [4:0]  model_tag = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint      sp;
        int          ia, ib;
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); p = sp; return p[63:32]; end
            3'd2: begin sp = longint'($signed(a)) * longint'({32'b0, b}); p = sp; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == MIN32 && b == 32'hFFFF_FFFF));
    endfunction

    // Per-cycle checker: busy/done timing and the held result/tag
    always @(negedge clk) begin
        logic exp_done;
        exp_done = (expq.size() > 0) && (cyc == expq[0].cyc);
        chk("done", 64'(done), 64'(exp_done));
        chk("busy", 64'(busy), 64'(expq.size() > 0));
        if (exp_done) begin
            model_res = expq[0].res;
            model_tag = expq[0].tag;
            void'(expq.pop_front());
        end
        chk("result", 64'(result), 64'(model_res));
        chk("tag_out", 64'(tag_out), 64'(model_tag));
    end

    task automatic scramble();
        funct3 = 3'($urandom_range(0, 7));
        src_a  = $urandom;
        src_b  = $urandom;
        tag_in = 5'($urandom_range(0, 31));
    endtask

    // Issue one op from idle and wait for its completion to be checked
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tg, input logic [31:0] exp_res, input bit hold);
        exp_t e;
        bit   finished;
        @(negedge clk);
        #1;
        start  = 1'b1;
        funct3 = f;
        src_a  = a;
        src_b  = b;
        tag_in = tg;
        @(posedge clk);
        #1;
        e.res = exp_res;
        e.tag = tg;
        e.cyc = cyc + (is_special(f, a, b) ? 0 : LAT);
        expq.push_back(e);
        if (!hold) start = 1'b0;
        scramble();
        finished = 1'b0;
        for (int i = 0; i < 60 && !finished; i++) begin
            @(negedge clk);
            #1;
            if (expq.size() == 0) finished = 1'b1;
            else scramble();
        end
        start = 1'b0;
        if (!finished) begin
            compared++;
            mism++;
            $display("FAIL timeout: op %0d never completed", f);
            expq.delete();
        end
    endtask

    task automatic run_model_op(input bit hold);
        logic [2:0]  f;
        logic [31:0] a, b;
        f = 3'($urandom_range(0, 7));
        a = pick();
        b = pick();
        run_op(f, a, b, 5'($urandom_range(0, 31)), model(f, a, b), hold);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MIN32;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Directed vectors with hand-computed results
    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[12] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB},
        '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF},
        '{3'd5, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'h7FFF_FFFC},
        '{3'd7, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'h0000_0001},
        '{3'd5, 32'd10,         32'd0,         5'd9,  32'hFFFF_FFFF},
        '{3'd7, 32'd10,         32'd0,         5'd10, 32'd10},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h0000_0000}
    };

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = '0;
        src_a  = '0;
        src_b  = '0;
        tag_in = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) begin
            chk("model_pin", 64'(model(vecs[i].f, vecs[i].a, vecs[i].b)), 64'(vecs[i].res));
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res, 1'b0);
        end

        // start held high through busy; consecutive ops back to back
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1);
        run_op(3'd4, 32'd100, 32'd7, 5'd13, 32'd14, 1'b1);

        // start and flush together in idle must not be accepted
        @(negedge clk);
        #1;
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'd0;
        src_a  = 32'd3;
        src_b  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        repeat (3) @(negedge clk);

        // flush in the middle of a multiply: no done, result held
        @(negedge clk);
        #1;
        start  = 1'b1;
        funct3 = 3'd0;
        src_a  = 32'd1234;
        src_b  = 32'd5678;
        tag_in = 5'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        expq.push_back('{res: 32'd7006652, tag: 5'd20, cyc: cyc + LAT});
        repeat (10) @(negedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        expq.delete();
        repeat (4) @(negedge clk);

        // reset in the middle of a divide: no done, everything back to zero
        @(negedge clk);
        #1;
        start  = 1'b1;
        funct3 = 3'd5;
        src_a  = 32'd1000;
        src_b  = 32'd3;
        tag_in = 5'd21;
        @(posedge clk);
        #1;
        start = 1'b0;
        expq.push_back('{res: 32'd333, tag: 5'd21, cyc: cyc + LAT});
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        expq.delete();
        model_res = '0;
        model_tag = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            run_model_op($urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
